pipe_if_dec_queue: RTL and testbench

PIPE_IF_DEC_QUEUE -- requirements
Module: pipe_if_dec_queue

---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_if_dec_queue.sv | 94 +++++++++
 tb/tb_pipe_if_dec_queue.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults for the fetch/decode pipeline boundary.
package pipe_pkg;

  localparam int unsigned ADDRESS_WIDTH_DEFAULT = 32;
  localparam int unsigned DATA_WIDTH_DEFAULT    = 32;

  // Decode sees an all-zero word whenever the queue has nothing to offer.
  localparam logic [DATA_WIDTH_DEFAULT-1:0] NOP_INSTRUCTION = '0;

endpackage

// File: rtl/pipe_if_dec_queue.sv
// Show-ahead instruction queue between fetch and decode.
// Holds up to DEPTH {PC, instruction} pairs; the head is always visible on the outputs.
module pipe_if_dec_queue
  import pipe_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Flush,
  input  logic                       i_Valid,
  input  logic [ADDRESS_WIDTH-1:0]   i_PC,
  input  logic [DATA_WIDTH-1:0]      i_Instruction,
  output logic                       o_Ready,
  input  logic                       i_Stall,
  output logic                       o_Valid,
  output logic [ADDRESS_WIDTH-1:0]   o_PC,
  output logic [DATA_WIDTH-1:0]      o_Instruction,
  output logic                       o_imembubble,
  output logic [$clog2(DEPTH):0]     o_Count
);

  localparam int unsigned PtrWidth   = $clog2(DEPTH);
  localparam int unsigned CountWidth = PtrWidth + 1;
  localparam logic [CountWidth-1:0] CountFull = CountWidth'(DEPTH);
  localparam logic [CountWidth-1:0] CountOne  = CountWidth'(1);
  localparam logic [PtrWidth-1:0]   PtrOne    = PtrWidth'(1);

  logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];

  logic [PtrWidth-1:0]   wr_ptr_q;
  logic [PtrWidth-1:0]   rd_ptr_q;
  logic [CountWidth-1:0] count_q;

  logic push;
  logic pop;

  // Handshake decode: flush suppresses both sides, ready depends on registered count only.
  always_comb begin
    o_Valid      = (count_q != '0);
    o_Ready      = (count_q != CountFull);
    o_imembubble = ~o_Valid;
    o_Count      = count_q;
    push         = i_Valid & o_Ready & ~i_Flush;
    pop          = o_Valid & ~i_Stall & ~i_Flush;
  end

  // Head entry, or a zero PC and NOP when empty.
  always_comb begin
    o_PC          = '0;
    o_Instruction = DATA_WIDTH'(NOP_INSTRUCTION);
    if (o_Valid) begin
      o_PC          = pc_mem[rd_ptr_q];
      o_Instruction = instr_mem[rd_ptr_q];
    end
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap by overflow.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_Flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (push && !pop) begin
        count_q <= count_q + CountOne;
      end else if (pop && !push) begin
        count_q <= count_q - CountOne;
      end
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge i_Clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= i_PC;
      instr_mem[wr_ptr_q] <= i_Instruction;
    end
  end

endmodule

// File: tb/tb_pipe_if_dec_queue.sv
// Directed self-checking bench for pipe_if_dec_queue (DEPTH=4, 32-bit PC and instruction).
module tb_pipe_if_dec_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        ready;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        bubble;
  logic [2:0]  count;

  int checks;
  int errors;

  pipe_if_dec_queue #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .DEPTH        (4)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Flush      (flush),
    .i_Valid      (in_valid),
    .i_PC         (in_pc),
    .i_Instruction(in_instr),
    .o_Ready      (ready),
    .i_Stall      (stall),
    .o_Valid      (out_valid),
    .o_PC         (out_pc),
    .o_Instruction(out_instr),
    .o_imembubble (bubble),
    .o_Count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or redriving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; stall = 1'b0;
    tick();
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (bubble !== 1'b1) begin errors++; $display("FAIL reset_bubble got %b want 1", bubble); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got pc=%h instr=%h want 0/0", out_pc, out_instr);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h8C01_0004; stall = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h8C01_0004) begin
      errors++; $display("FAIL single_head got v=%b pc=%h instr=%h want 1/100/8c010004",
                         out_valid, out_pc, out_instr);
    end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    tick();
    checks++; if (out_valid !== 1'b0 || bubble !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++; $display("FAIL single_drain got v=%b b=%b pc=%h instr=%h want 0/1/0/0",
                         out_valid, bubble, out_pc, out_instr);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pc = 32'(4 * i); in_instr = instr_of(32'(4 * i));
      tick();
      if (i == 3) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", ready); end
      end
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i] || out_instr !== instr_of(exp_pc[i])) begin
        errors++; $display("FAIL full_order[%0d] got v=%b pc=%h want pc=%h", i, out_valid, out_pc, exp_pc[i]);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL full_empty got v=%b count=%0d want 0/0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * i); in_instr = instr_of(in_pc);
      q.push_back(in_pc);
      tick();
    end
    stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_pc = 32'h208 + 32'(4 * k); in_instr = instr_of(in_pc);
      q.push_back(in_pc);
      void'(q.pop_front());
      tick();
      checks++; if (count !== 3'd2 || out_pc !== q[0] || out_instr !== instr_of(q[0])) begin
        errors++; $display("FAIL steady[%0d] got count=%0d pc=%h want 2/%h", k, count, out_pc, q[0]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_pc !== q[1]) begin
      errors++; $display("FAIL steady_tail got pc=%h want %h", out_pc, q[1]);
    end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL steady_drain got %0d want 0", count); end
  endtask

  task automatic test_flush();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h500 + 32'(4 * i); in_instr = instr_of(in_pc);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h5FC; in_instr = instr_of(in_pc);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear got count=%0d v=%b want 0/0", count, out_valid);
    end
    tick();
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_not_stored got count=%0d v=%b want 0/0", count, out_valid);
    end
    stall = 1'b0; in_valid = 1'b1; in_pc = 32'h300; in_instr = instr_of(in_pc);
    tick();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h300 || count !== 3'd1) begin
      errors++; $display("FAIL flush_repush got pc=%h count=%0d want 300/1", out_pc, count);
    end
    tick();
  endtask

  task automatic test_full_push_pop();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h600 + 32'(4 * i); in_instr = instr_of(in_pc);
      tick();
    end
    stall = 1'b0; in_valid = 1'b1; in_pc = 32'h999; in_instr = instr_of(in_pc);
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3 || out_pc !== 32'h604) begin
      errors++; $display("FAIL fullpp got count=%0d pc=%h want 3/604", count, out_pc);
    end
    tick();
    tick();
    checks++; if (out_pc !== 32'h60C || count !== 3'd1) begin
      errors++; $display("FAIL fullpp_tail got pc=%h count=%0d want 60c/1", out_pc, count);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin
      errors++; $display("FAIL fullpp_dropped got v=%b pc=%h want 0", out_valid, out_pc);
    end
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h700 + 32'(4 * i); in_instr = instr_of(in_pc);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL areset_pre got %0d want 2", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0
                  || ready !== 1'b1) begin
      errors++; $display("FAIL areset_mid got count=%0d v=%b pc=%h instr=%h rdy=%b want 0/0/0/0/1",
                         count, out_valid, out_pc, out_instr, ready);
    end
    #1 rst = 1'b0;
    stall = 1'b0; in_valid = 1'b1; in_pc = 32'h400; in_instr = instr_of(in_pc);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400 || count !== 3'd1) begin
      errors++; $display("FAIL areset_first_push got v=%b pc=%h count=%0d want 1/400/1",
                         out_valid, out_pc, count);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_flush();
    test_full_push_pop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
